mx_e5m2_block_sched: RTL and testbench



---
 rtl/mx_e5m2_block_sched.sv | 194 +++++++++++++++++++
 tb/tb_mx_e5m2_block_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mx_e5m2_block_sched.sv
// mx_e5m2_block_sched
// Collects one MX block of FP32 elements, keeps a 12-bit reduced copy of each
// ({sign, exp, mant[22:20]}), derives the shared E5M2 scale from the largest
// exponent, then replays the block through an external combinational
// converter and streams the 8-bit results out on a valid/ready interface.

module mx_e5m2_block_sched #(
    parameter int BLOCK_SIZE = 32,
    parameter int IDX_W      = 5,
    parameter int ELEM_BIAS  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [11:0] conv_v_i,
    output logic [7:0]  conv_x,
    input  logic [7:0]  conv_p_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [7:0]  out_scale,
    output logic        out_first,
    output logic        out_last,
    output logic        busy,
    output logic        err_len
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SCALE,
        S_EMIT,
        S_DRAIN
    } state_t;

    state_t            r_state;
    logic [11:0]       r_buf [BLOCK_SIZE];
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [7:0]        r_max_exp;
    logic              r_any_inf;
    logic [7:0]        r_scale;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic              r_out_first;
    logic              r_out_last;
    logic              r_err_len;

    logic              w_in_ready;
    logic              w_accept;
    logic [7:0]        w_in_exp;
    logic [11:0]       w_reduced;
    logic              w_blk_end;
    logic              w_early_last;
    logic              w_load;
    logic              w_unused;

    // Shared scale: all-ones when any element is Inf/NaN, otherwise the max
    // exponent pulled down by the E5M2 emax offset, floored at zero.
    function automatic logic [7:0] f_scale(input logic [7:0] max_exp,
                                           input logic       any_inf);
        logic [7:0] v;
        if (any_inf) begin
            v = 8'hFF;
        end else if ({1'b0, max_exp} >= 9'(ELEM_BIAS)) begin
            v = max_exp - 8'(ELEM_BIAS);
        end else begin
            v = 8'h00;
        end
        return v;
    endfunction

    // Only the top three mantissa bits survive into the reduced form.
    assign w_unused     = ^in_data[19:0];

    assign w_in_ready   = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_accept     = in_valid && w_in_ready;
    assign w_in_exp     = in_data[30:23];
    assign w_reduced    = {in_data[31], in_data[30:23], in_data[22:20]};
    assign w_blk_end    = (r_wr_idx == LAST_IDX);
    assign w_early_last = w_accept && in_last && !w_blk_end;
    assign w_load       = (r_state == S_EMIT) && (!r_out_valid || out_ready);

    // Element buffer: written on accept; an early in_last zero-fills every
    // slot above the closing one in the same cycle so the block can close.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_idx] <= w_reduced;
            if (w_early_last) begin
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    if (i > int'(r_wr_idx)) begin
                        r_buf[i] <= 12'h000;
                    end
                end
            end
        end
    end

    // Block sequencer: collect, compute scale, replay through converter, drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_max_exp   <= 8'h00;
            r_any_inf   <= 1'b0;
            r_scale     <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (w_accept) begin
                        r_wr_idx <= r_wr_idx + IDX_W'(1);
                        if (w_in_exp > r_max_exp) begin
                            r_max_exp <= w_in_exp;
                        end
                        if (w_in_exp == 8'hFF) begin
                            r_any_inf <= 1'b1;
                        end
                        if (w_blk_end) begin
                            // The block always closes on its final slot; a
                            // missing in_last is only flagged.
                            r_state <= S_SCALE;
                            if (!in_last) begin
                                r_err_len <= 1'b1;
                            end
                        end else if (in_last) begin
                            r_state   <= S_SCALE;
                            r_err_len <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end

                S_SCALE: begin
                    r_scale  <= f_scale(r_max_exp, r_any_inf);
                    r_rd_idx <= '0;
                    r_state  <= S_EMIT;
                end

                S_EMIT: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= conv_p_i;
                        r_out_first <= (r_rd_idx == '0);
                        r_out_last  <= (r_rd_idx == LAST_IDX);
                        r_rd_idx    <= r_rd_idx + IDX_W'(1);
                        if (r_rd_idx == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // Hold the last result until taken, then rearm for the
                    // next block.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_max_exp   <= 8'h00;
                        r_any_inf   <= 1'b0;
                        r_wr_idx    <= '0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = (r_state != S_IDLE);
    assign err_len   = r_err_len;
    assign conv_v_i  = (r_state == S_EMIT) ? r_buf[r_rd_idx] : 12'h000;
    assign conv_x    = r_scale;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_scale = r_scale;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_mx_e5m2_block_sched.sv
// Testbench for mx_e5m2_block_sched: randomized blocks, a stand-in converter,
// and a queue-based scoreboard fed from a block-level reference model.

module tb_mx_e5m2_block_sched;

    localparam int BS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [11:0] conv_v_i;
    logic [7:0]  conv_x;
    logic [7:0]  conv_p_i;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_scale;
    logic        out_first;
    logic        out_last;
    logic        busy;
    logic        err_len;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] scale;
        logic       first;
        logic       last;
    } exp_t;

    exp_t        q[$];
    logic [31:0] blk [BS];
    int          checks = 0;
    int          errs   = 0;
    int          cyc    = 0;
    int          rdy_mode = 0;
    int          pat_i  = 0;

    // monitor state
    bit          hold_pend = 0;
    bit          done_pend = 0;
    exp_t        hold_v;
    int          first_cyc = 0;

    always #5 clk = ~clk;

    // Stand-in converter: any deterministic mix of element and scale bits.
    function automatic logic [7:0] conv_fn(input logic [11:0] v, input logic [7:0] x);
        return ((v[7:0] ^ {v[11:8], v[11:8]}) * 8'd5) + x;
    endfunction

    assign conv_p_i = conv_fn(conv_v_i, conv_x);

    mx_e5m2_block_sched #(.BLOCK_SIZE(BS), .IDX_W(5), .ELEM_BIAS(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .conv_v_i(conv_v_i), .conv_x(conv_x), .conv_p_i(conv_p_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_scale(out_scale), .out_first(out_first), .out_last(out_last),
        .busy(busy), .err_len(err_len)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mk(input logic s, input logic [7:0] e, input logic [22:0] m);
        return {s, e, m};
    endfunction

    // Reference model: the first n slots hold the accepted elements, the rest
    // are zero; scale follows from max exponent / Inf presence.
    task automatic push_expected(input int n);
        int   maxe = 0;
        bit   inf  = 0;
        int   sc;
        exp_t it;
        logic [11:0] red;
        for (int k = 0; k < n; k++) begin
            int e = int'(blk[k][30:23]);
            if (e > maxe) maxe = e;
            if (e == 255) inf = 1;
        end
        if (inf) sc = 255;
        else if (maxe >= 15) sc = maxe - 15;
        else sc = 0;
        for (int k = 0; k < BS; k++) begin
            red      = (k < n) ? {blk[k][31], blk[k][30:23], blk[k][22:20]} : 12'h000;
            it.data  = conv_fn(red, 8'(sc));
            it.scale = 8'(sc);
            it.first = (k == 0);
            it.last  = (k == BS - 1);
            q.push_back(it);
        end
    endtask

    // Sends n elements; in_last is raised on element last_pos (-1: never).
    task automatic send_elems(input int n, input int last_pos);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            in_valid = 1'b1;
            in_data  = blk[k];
            in_last  = (k == last_pos);
            @(negedge clk);
            while (!in_ready && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                checks++;
                errs++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'h0;
    endtask

    task automatic wait_done();
        int w = 0;
        while (q.size() > 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: got %0d left expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int last_pos);
        int n = (last_pos >= 0 && last_pos < BS - 1) ? last_pos + 1 : BS;
        send_elems(n, last_pos);
        push_expected(n);
        wait_done();
    endtask

    task automatic check_reset_state();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_first", 32'(out_first), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_err_len",   32'(err_len),   32'd0);
        check("rst_out_scale", 32'(out_scale), 32'd0);
        check("rst_conv_v_i",  32'(conv_v_i),  32'd0);
        check("rst_conv_x",    32'(conv_x),    32'd0);
    endtask

    always @(posedge clk) cyc++;

    // Downstream ready driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
                    pat_i++;
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stalls hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
            done_pend = 0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", {out_data, out_scale, 6'd0, out_first, out_last},
                      {hold_v.data, hold_v.scale, 6'd0, hold_v.first, hold_v.last});
            end
            if (done_pend) begin
                check("ready_after_last", {30'd0, in_ready, busy}, {30'd0, 1'b1, 1'b0});
                done_pend = 0;
            end
            if (q.size() > 0) begin
                check("in_ready_low", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_out: got data %h expected no output", out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_beat", {out_data, out_scale, 6'd0, out_first, out_last},
                          {e.data, e.scale, 6'd0, e.first, e.last});
                    if (e.first) first_cyc = cyc;
                    if (e.last) begin
                        done_pend = 1;
                        if (rdy_mode == 0) begin
                            check("burst_len", 32'(cyc - first_cyc), 32'd31);
                        end
                    end
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_v.data  = out_data;
            hold_v.scale = out_scale;
            hold_v.first = out_first;
            hold_v.last  = out_last;
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;

        // All ones (1.0)
        rdy_mode = 0;
        for (int k = 0; k < BS; k++) blk[k] = 32'h3F800000;
        run_block(BS - 1);
        check("scale_ones", 32'(out_scale), 32'd112);
        check("err_ones", 32'(err_len), 32'd0);

        // Exponent ramp 100..131
        for (int k = 0; k < BS; k++)
            blk[k] = mk(1'($urandom_range(0, 1)), 8'(100 + k), 23'($urandom));
        run_block(BS - 1);
        check("scale_ramp", 32'(out_scale), 32'd116);
        check("err_ramp", 32'(err_len), 32'd0);

        // One Inf among 2.0 values
        for (int k = 0; k < BS; k++) blk[k] = 32'h40000000;
        blk[7] = 32'h7F800000;
        run_block(BS - 1);
        check("scale_inf", 32'(out_scale), 32'hFF);

        // Tiny exponents: scale floors at zero
        for (int k = 0; k < BS; k++)
            blk[k] = mk(1'($urandom_range(0, 1)), 8'd3, 23'($urandom));
        run_block(BS - 1);
        check("scale_tiny", 32'(out_scale), 32'd0);

        // Backpressure pattern 1-0-0-1
        rdy_mode = 1;
        for (int k = 0; k < BS; k++)
            blk[k] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom));
        run_block(BS - 1);
        check("err_bp", 32'(err_len), 32'd0);

        // Early in_last on element 19: zero-filled tail
        rdy_mode = 2;
        for (int k = 0; k < BS; k++)
            blk[k] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(20, 200)), 23'($urandom));
        run_block(19);
        check("err_early", 32'(err_len), 32'd1);

        // Reset in the middle of collecting: nothing emitted, clean state
        for (int k = 0; k < BS; k++)
            blk[k] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom));
        send_elems(10, -1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < BS; k++)
            blk[k] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom));
        run_block(BS - 1);
        check("err_after_rst", 32'(err_len), 32'd0);

        // Random blocks, occasional Inf
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < BS; k++)
                blk[k] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom));
            if (b == 1) blk[$urandom_range(0, BS - 1)] = 32'hFF800000;
            run_block(BS - 1);
        end
        check("err_random", 32'(err_len), 32'd0);

        // Missing in_last: block still closes, error flagged
        for (int k = 0; k < BS; k++)
            blk[k] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom));
        run_block(-1);
        check("err_missing", 32'(err_len), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
